// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package  : mips_defs
//  Purpose  : Shared MIPS opcode constants, request-kind codes and the
//             encoder FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_defs;

  // Primary opcode field values (instruction bits 31:26)
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  // Request kind codes; 6 and 7 are illegal
  localparam logic [2:0] c_kind_r    = 3'd0;
  localparam logic [2:0] c_kind_lw   = 3'd1;
  localparam logic [2:0] c_kind_sw   = 3'd2;
  localparam logic [2:0] c_kind_beq  = 3'd3;
  localparam logic [2:0] c_kind_addi = 3'd4;
  localparam logic [2:0] c_kind_j    = 3'd5;

  // Encoder control states
  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } enc_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_word_enc.sv
`default_nettype none
// ============================================================================
//  Module   : inst_word_enc
//  Purpose  : Combinational assembly of a 32-bit MIPS instruction word from
//             request kind and fields; flags kinds with no encoding.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_word_enc
  import mips_defs::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the instruction format for the requested kind
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (kind)
      c_kind_r:    word = {c_op_rtype, rs, rt, rd, 5'b00000, funct};
      c_kind_lw:   word = {c_op_lw,    rs, rt, imm};
      c_kind_sw:   word = {c_op_sw,    rs, rt, imm};
      c_kind_beq:  word = {c_op_beq,   rs, rt, imm};
      c_kind_addi: word = {c_op_addi,  rs, rt, imm};
      c_kind_j:    word = {c_op_j,     target};
      default:     illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder
//  Purpose  : Accepts instruction requests, encodes them and writes the words
//             sequentially into instruction memory starting at address 0.
//             Tracks fill level, end of program and illegal requests.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_encoder
  import mips_defs::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              finish,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] c_count_one = {{ADDR_W{1'b0}}, 1'b1};

  enc_state_e        r_state;
  enc_state_e        w_state_nxt;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_hs;
  logic              w_write;
  logic              w_full;

  inst_word_enc u_word_enc (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (w_word),
    .illegal (w_illegal)
  );

  // Count never exceeds the memory depth, so its top bit is the full flag
  // and the low bits double as the non-wrapping write pointer.
  assign w_full  = r_count[ADDR_W];
  assign w_hs    = in_valid & in_ready;
  // A handshake coinciding with start belongs to the abandoned program
  assign w_write = w_hs & ~w_illegal & ~start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= st_idle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic plus state-derived handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    done        = 1'b0;
    case (r_state)
      st_idle: begin
        if (start) w_state_nxt = st_run;
      end
      st_run: begin
        in_ready = ~w_full;
        if (start)       w_state_nxt = st_run;
        else if (finish) w_state_nxt = st_done;
      end
      st_done: begin
        done = 1'b1;
        if (start) w_state_nxt = st_run;
      end
      default: w_state_nxt = st_idle;
    endcase
  end

  // Write register, fill counter and sticky illegal-request flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= w_write;
      if (w_write) begin
        r_mem_addr  <= r_count[ADDR_W-1:0];
        r_mem_wdata <= w_word;
      end
      if (start) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_write)          r_count <= r_count + c_count_one;
        if (w_hs & w_illegal) r_err   <= 1'b1;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign count     = r_count;
  assign full      = w_full;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_encoder
//  Purpose  : Self-checking bench for inst_encoder; two instances (depth 256
//             and depth 4) share stimulus and are compared against a
//             behavioural model every cycle, plus literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        finish;

  logic        a_in_ready, a_mem_we, a_full, a_done, a_err;
  logic [7:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [8:0]  a_count;

  logic        b_in_ready, b_mem_we, b_full, b_done, b_err;
  logic [1:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  inst_encoder #(.ADDR_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .finish(finish), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .count(a_count),
    .full(a_full), .done(a_done), .err(a_err)
  );

  inst_encoder #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .finish(finish), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .count(b_count),
    .full(b_full), .done(b_done), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // mode: 0 idle, 1 running, 2 finished
  int          m_mode [2];
  int          m_cnt  [2];
  bit          m_err  [2];
  bit          m_we   [2];
  int          m_addr [2];
  logic [31:0] m_wd   [2];
  int          depth  [2] = '{256, 4};

  function automatic logic [31:0] enc(input int kind, input int rs, input int rt,
                                      input int rd, input int funct, input int imm,
                                      input int tgt);
    longint op;
    longint w;
    case (kind)
      0: op = 0;
      1: op = 35;
      2: op = 43;
      3: op = 4;
      4: op = 8;
      default: op = 2;
    endcase
    if (kind == 0)
      w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + funct;
    else if (kind == 5)
      w = op * 64'd67108864 + tgt;
    else
      w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
    return w[31:0];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit rdy, hs, legal;
      rdy   = (m_mode[k] == 1) && (m_cnt[k] < depth[k]);
      hs    = in_valid && rdy;
      legal = (int'(in_kind) < 6);
      if (rst) begin
        m_mode[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
        m_we[k] = 1'b0; m_addr[k] = 0; m_wd[k] = 32'h0;
      end else begin
        m_we[k] = hs && legal && !start;
        if (m_we[k]) begin
          m_addr[k] = m_cnt[k];
          m_wd[k]   = enc(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                          int'(in_funct), int'(in_imm), int'(in_target));
        end
        if (start) begin
          m_cnt[k] = 0; m_err[k] = 1'b0; m_mode[k] = 1;
        end else begin
          if (m_we[k]) m_cnt[k] = m_cnt[k] + 1;
          if (hs && !legal) m_err[k] = 1'b1;
          if (m_mode[k] == 1 && finish) m_mode[k] = 2;
        end
      end
    end
  end

  // -------------------------------------------------------------- checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic rdy, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] cnt, input logic fl, input logic dn,
                     input logic er);
    string p;
    p = (k == 0) ? "a_" : "b_";
    chk({p, "in_ready"}, 32'(rdy), 32'((m_mode[k] == 1) && (m_cnt[k] < depth[k])));
    chk({p, "mem_we"},   32'(we),  32'(m_we[k]));
    if (m_we[k]) begin
      chk({p, "mem_addr"},  addr, 32'(m_addr[k]));
      chk({p, "mem_wdata"}, wd,   m_wd[k]);
    end
    chk({p, "count"}, cnt,      32'(m_cnt[k]));
    chk({p, "full"},  32'(fl),  32'(m_cnt[k] == depth[k]));
    chk({p, "done"},  32'(dn),  32'(m_mode[k] == 2));
    chk({p, "err"},   32'(er),  32'(m_err[k]));
  endtask

  // Compare both instances to the model every cycle once reset has applied
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, a_in_ready, a_mem_we, 32'(a_mem_addr), a_mem_wdata, 32'(a_count),
          a_full, a_done, a_err);
      cmp(1, b_in_ready, b_mem_we, 32'(b_mem_addr), b_mem_wdata, 32'(b_count),
          b_full, b_done, b_err);
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic clear_inputs();
    start = 1'b0; in_valid = 1'b0; finish = 1'b0; in_kind = 3'd0;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_funct = 6'd0;
    in_imm = 16'd0; in_target = 26'd0;
  endtask

  task automatic idle();
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    clear_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic setreq(input int kind, input int rs, input int rt, input int rd,
                        input int funct, input int imm, input int tgt, input bit fin);
    in_valid = 1'b1; in_kind = 3'(kind); in_rs = 5'(rs); in_rt = 5'(rt);
    in_rd = 5'(rd); in_funct = 6'(funct); in_imm = 16'(imm);
    in_target = 26'(tgt); finish = fin;
  endtask

  task automatic send(input int kind, input int rs, input int rt, input int rd,
                      input int funct, input int imm, input int tgt, input bit fin);
    setreq(kind, rs, rt, rd, funct, imm, tgt, fin);
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_mem_we", 32'(a_mem_we), 32'h0);
    chk("rst_count",  32'(a_count),  32'h0);
    chk("rst_ready",  32'(a_in_ready), 32'h0);
    chk("rst_done",   32'(a_done),   32'h0);
    rst = 1'b0;
    idle();

    // finish while idle has no effect
    finish = 1'b1;
    @(negedge clk);
    chk("idle_finish_done", 32'(a_done), 32'h0);
    idle();

    // single lw
    pulse_start();
    send(1, 16, 8, 0, 0, 4, 0, 1'b0);
    chk("lw_we",    32'(a_mem_we),   32'h1);
    chk("lw_addr",  32'(a_mem_addr), 32'h0);
    chk("lw_wdata", a_mem_wdata,     32'h8E08_0004);
    chk("lw_count", 32'(a_count),    32'h1);
    idle();

    // back-to-back R, sw, beq
    pulse_start();
    send(0, 8, 9, 10, 32'h20, 0, 0, 1'b0);
    chk("r_wdata", a_mem_wdata, 32'h0109_5020);
    chk("r_addr",  32'(a_mem_addr), 32'h0);
    send(2, 16, 8, 0, 0, 8, 0, 1'b0);
    chk("sw_wdata", a_mem_wdata, 32'hAE08_0008);
    chk("sw_addr",  32'(a_mem_addr), 32'h1);
    send(3, 8, 9, 0, 0, 32'hFFFF, 0, 1'b0);
    chk("beq_wdata", a_mem_wdata, 32'h1109_FFFF);
    chk("beq_addr",  32'(a_mem_addr), 32'h2);
    idle();

    // addi then j with finish; then a request while done is ignored
    pulse_start();
    send(4, 0, 8, 0, 0, 5, 0, 1'b0);
    chk("addi_wdata", a_mem_wdata, 32'h2008_0005);
    send(5, 0, 0, 0, 0, 0, 32'h10, 1'b1);
    chk("j_wdata",  a_mem_wdata,     32'h0800_0010);
    chk("j_we",     32'(a_mem_we),   32'h1);
    chk("j_done",   32'(a_done),     32'h1);
    chk("j_ready",  32'(a_in_ready), 32'h0);
    send(1, 1, 2, 0, 0, 3, 0, 1'b1);
    chk("done_no_we", 32'(a_mem_we), 32'h0);
    idle();

    // fill the depth-4 instance
    pulse_start();
    for (int i = 0; i < 4; i++) send(4, i, i + 1, 0, 0, i * 3, 0, 1'b0);
    chk("b_full",  32'(b_full),     32'h1);
    chk("b_count", 32'(b_count),    32'h4);
    chk("b_ready", 32'(b_in_ready), 32'h0);
    send(1, 3, 4, 0, 0, 7, 0, 1'b0);
    chk("b_fifth_we", 32'(b_mem_we), 32'h0);
    idle();

    // illegal kind, then restart clears err
    pulse_start();
    send(1, 1, 1, 0, 0, 1, 0, 1'b0);
    send(6, 1, 2, 3, 4, 5, 6, 1'b0);
    chk("ill_we",  32'(a_mem_we), 32'h0);
    chk("ill_err", 32'(a_err),    32'h1);
    send(7, 0, 0, 0, 0, 0, 0, 1'b0);
    idle();
    chk("ill_err_sticky", 32'(a_err), 32'h1);
    pulse_start();
    chk("restart_err",   32'(a_err),   32'h0);
    chk("restart_count", 32'(a_count), 32'h0);
    send(1, 2, 3, 0, 0, 9, 0, 1'b0);
    chk("restart_addr", 32'(a_mem_addr), 32'h0);
    chk("restart_we",   32'(a_mem_we),   32'h1);

    // start in RUN with a handshake: that write is dropped
    setreq(2, 4, 5, 0, 0, 6, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    chk("drop_we",    32'(a_mem_we), 32'h0);
    chk("drop_count", 32'(a_count),  32'h0);
    idle();

    // rst in the handshake cycle: nothing written
    setreq(1, 16, 8, 0, 0, 4, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hs_we", 32'(a_mem_we), 32'h0);
    rst = 1'b0;
    idle();

    // rst the cycle after a handshake: all outputs back to reset values
    pulse_start();
    send(1, 16, 8, 0, 0, 4, 0, 1'b0);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_we",    32'(a_mem_we),   32'h0);
    chk("rst2_addr",  32'(a_mem_addr), 32'h0);
    chk("rst2_wdata", a_mem_wdata,     32'h0);
    chk("rst2_count", 32'(a_count),    32'h0);
    chk("rst2_err",   32'(a_err),      32'h0);
    chk("rst2_ready", 32'(a_in_ready), 32'h0);
    rst = 1'b0;
    idle();
    idle();
    chk("rst2_quiet_we", 32'(a_mem_we), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, width of the word address into instruction memory (depth 2^ADDR_W).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle pulse: begin a new program at word address 0.
REQ-005 in_valid  input  1  instruction request present.
REQ-006 in_ready  output  1  encoder accepts a request this cycle.
REQ-007 in_kind  input  3  0=R-type, 1=lw, 2=sw, 3=beq, 4=addi, 5=j, 6/7 illegal.
REQ-008 in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-009 in_funct  input  6  R-type function field.
REQ-010 in_imm  input  16  I-type immediate; in_target  input  26  jump target.
REQ-011 finish  input  1  end of program.
REQ-012 mem_we  output  1  instruction-memory write strobe.
REQ-013 mem_addr  output  ADDR_W  word address; mem_wdata  output  32  encoded instruction.
REQ-014 count  output  ADDR_W+1  words written since start; full, done, err  output  1 each  status.

Function
REQ-015 FSM states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE on finish; DONE->RUN on start; start in RUN restarts RUN.
REQ-016 in_ready SHALL be 1 only in RUN with full=0; handshake = in_valid & in_ready.
REQ-017 Encoding: R = {000000,rs,rt,rd,00000,funct}; lw {100011,rs,rt,imm}; sw {101011,rs,rt,imm}; beq {000100,rs,rt,imm}; addi {001000,rs,rt,imm}; j {000010,target}.
REQ-018 Latency: a legal request accepted in cycle N SHALL produce mem_we=1 with mem_addr=write pointer and mem_wdata=encoded word in cycle N+1, registered.
REQ-019 After each write the pointer and count SHALL increment by 1; back-to-back accepts SHALL write every cycle with no bubble.
REQ-020 full SHALL assert when count = 2^ADDR_W; the pointer SHALL NOT wrap; in_ready deasserts.
REQ-021 Illegal in_kind SHALL be accepted, produce no write, and set err sticky until start or rst.
REQ-022 finish with a handshake in the same cycle: the instruction SHALL be written, then DONE.
REQ-023 finish in IDLE or DONE SHALL be ignored; in_valid outside RUN SHALL be ignored.
REQ-024 done SHALL be 1 exactly while in DONE.
REQ-025 start SHALL clear pointer, count, full, and err in the next cycle; a write pending from the start cycle's handshake SHALL be dropped.
REQ-026 mem_we SHALL be 0 in every cycle with no write pending.

Reset
REQ-027 rst SHALL force IDLE, with mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, done=0, err=0, and in_ready=0 in the following cycle.
REQ-028 rst mid-program SHALL cancel any pending write; no write is issued after rst.

Structure
REQ-029 Opcode constants (000000, 100011, 101011, 000100, 001000, 000010) and in_kind codes SHALL live in the shared package mips_defs, which the main decoder also uses.
REQ-030 Word assembly SHALL be a combinational sub-module inst_word_enc (kind and fields -> 32-bit word, plus illegal flag); the FSM, pointer, and write register are in inst_encoder.

Verification
REQ-031 start; lw rs=16 rt=8 imm=4 -> next cycle mem_we=1, addr=0, wdata=0x8E080004, count=1.
REQ-032 Back-to-back: R rs=8 rt=9 rd=10 funct=0x20; sw rs=16 rt=8 imm=8; beq rs=8 rt=9 imm=0xFFFF -> 0x01095020, 0xAE080008, 0x1109FFFF at addr 0,1,2 on consecutive cycles.
REQ-033 addi rs=0 rt=8 imm=5 then j target=0x10 with finish in the same cycle -> 0x20080005, then 0x08000010, then done=1 and in_ready=0.
REQ-034 ADDR_W=2: 4 accepted requests -> full=1, count=4, in_ready=0; a fifth in_valid -> no write.
REQ-035 in_kind=6 -> no mem_we, err=1; start -> err=0, count=0, next write at addr 0.
REQ-036 rst asserted the cycle after a handshake -> mem_we stays 0, all outputs at reset values.
